// File: rtl/datapath_pkg.sv
// Shared constants for the single-bus datapath: ALU opcodes and bus-source indices.
package datapath_pkg;

  localparam int DATA_W = 32;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  // General registers occupy SRC_R0 .. SRC_R0+15.
  typedef logic [4:0] bus_sel_t;
  localparam bus_sel_t SRC_NONE   = 5'd0;
  localparam bus_sel_t SRC_PC     = 5'd1;
  localparam bus_sel_t SRC_MDR    = 5'd2;
  localparam bus_sel_t SRC_ZHI    = 5'd3;
  localparam bus_sel_t SRC_ZLO    = 5'd4;
  localparam bus_sel_t SRC_HI     = 5'd5;
  localparam bus_sel_t SRC_LO     = 5'd6;
  localparam bus_sel_t SRC_INPORT = 5'd7;
  localparam bus_sel_t SRC_R0     = 5'd8;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A comes from Y, B from the bus; 64-bit result feeds Z.
module alu
  import datapath_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  opcode,
  input  logic        IncPC,
  output logic [63:0] C
);

  logic        [4:0]  sa;
  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic signed [63:0] prod;
  logic signed [31:0] quot;
  logic signed [31:0] rem;

  assign sa    = B[4:0];
  assign a_ext = {{32{A[31]}}, A};
  assign b_ext = {{32{B[31]}}, B};
  assign prod  = a_ext * b_ext;

  // Divide-by-zero is caught here so the operators never see a zero divisor.
  always_comb begin
    quot = '0;
    rem  = '0;
    if (B != '0) begin
      quot = $signed(A) / $signed(B);
      rem  = $signed(A) % $signed(B);
    end
  end

  always_comb begin
    C = '0;
    if (IncPC) begin
      C = {32'd0, B + 32'd1};
    end else begin
      case (opcode)
        OP_LD, OP_LDI, OP_ST,
        OP_ADD, OP_ADDI:  C = {32'd0, A + B};
        OP_SUB:           C = {32'd0, A - B};
        OP_AND, OP_ANDI:  C = {32'd0, A & B};
        OP_OR, OP_ORI:    C = {32'd0, A | B};
        OP_ROR:           C = {32'd0, (A >> sa) | (A << (6'd32 - {1'b0, sa}))};
        OP_ROL:           C = {32'd0, (A << sa) | (A >> (6'd32 - {1'b0, sa}))};
        OP_SHR:           C = {32'd0, A >> sa};
        OP_SHRA:          C = {32'd0, $signed(A) >>> sa};
        OP_SHL:           C = {32'd0, A << sa};
        OP_MUL:           C = prod;
        OP_DIV:           C = (B == '0) ? '0 : {rem, quot};
        OP_NEG:           C = {32'd0, 32'd0 - B};
        OP_NOT:           C = {32'd0, ~B};
        default:          C = '0;
      endcase
    end
  end

endmodule

// File: rtl/datapath.sv
// Single-bus CPU datapath: register file, PC, HI/LO, Y, Z, MAR, MDR and ALU on one
// shared bus; every enable and select is driven externally each cycle.
module datapath
  import datapath_pkg::*;
(
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] Mdatain,
  input  logic        Read,
  input  logic        IncPC,
  input  logic [15:0] Rin,
  input  logic [15:0] Rout,
  input  logic        PCin,
  input  logic        Zin,
  input  logic        MDRin,
  input  logic        MARin,
  input  logic        Yin,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        PCout,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        MDRout,
  input  logic        InPortout,
  input  logic [4:0]  opcode,
  input  logic [31:0] InPort_data,
  output logic [31:0] BusMuxOut,
  output logic [31:0] MAR_q
);

  logic [31:0] r_q [16];
  logic [31:0] r_d [16];
  logic [31:0] pc_q, pc_d, hi_q, hi_d, lo_q, lo_d, y_q, y_d;
  logic [31:0] mar_q, mar_d, mdr_q, mdr_d;
  logic [63:0] z_q, z_d;
  logic [63:0] alu_c;
  logic [31:0] bus;
  bus_sel_t    bus_sel;

  // Encoder: later assignments win, so the lowest-priority source is written first.
  always_comb begin
    bus_sel = SRC_NONE;
    for (int n = 0; n < 16; n++) begin
      if (Rout[n]) bus_sel = SRC_R0 + 5'(n);
    end
    if (InPortout) bus_sel = SRC_INPORT;
    if (LOout)     bus_sel = SRC_LO;
    if (HIout)     bus_sel = SRC_HI;
    if (Zlowout)   bus_sel = SRC_ZLO;
    if (Zhighout)  bus_sel = SRC_ZHI;
    if (MDRout)    bus_sel = SRC_MDR;
    if (PCout)     bus_sel = SRC_PC;
  end

  always_comb begin
    bus = '0;
    case (bus_sel)
      SRC_NONE:   bus = '0;
      SRC_PC:     bus = pc_q;
      SRC_MDR:    bus = mdr_q;
      SRC_ZHI:    bus = z_q[63:32];
      SRC_ZLO:    bus = z_q[31:0];
      SRC_HI:     bus = hi_q;
      SRC_LO:     bus = lo_q;
      SRC_INPORT: bus = InPort_data;
      default:    bus = r_q[4'(bus_sel - SRC_R0)];
    endcase
  end

  alu u_alu (
    .A      (y_q),
    .B      (bus),
    .opcode (opcode),
    .IncPC  (IncPC),
    .C      (alu_c)
  );

  always_comb begin
    for (int n = 0; n < 16; n++) begin
      r_d[n] = Rin[n] ? bus : r_q[n];
    end
    pc_d  = PCin  ? bus : pc_q;
    hi_d  = HIin  ? bus : hi_q;
    lo_d  = LOin  ? bus : lo_q;
    y_d   = Yin   ? bus : y_q;
    mar_d = MARin ? bus : mar_q;
    mdr_d = MDRin ? (Read ? Mdatain : bus) : mdr_q;
    z_d   = Zin   ? alu_c : z_q;
  end

  always_ff @(posedge Clock) begin
    if (clear) begin
      r_q   <= '{default: '0};
      pc_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      y_q   <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      z_q   <= '0;
    end else begin
      r_q   <= r_d;
      pc_q  <= pc_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      y_q   <= y_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      z_q   <= z_d;
    end
  end

  assign BusMuxOut = bus;
  assign MAR_q     = mar_q;

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: stimulus queues expected bus/MAR values, a monitor
// on the falling edge pops and compares them against a behavioural model.
module tb_datapath;
  import datapath_pkg::*;

  logic        Clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] Mdatain = '0, InPort_data = '0;
  logic        Read = 0, IncPC = 0;
  logic [15:0] Rin = '0, Rout = '0;
  logic        PCin = 0, Zin = 0, MDRin = 0, MARin = 0, Yin = 0, HIin = 0, LOin = 0;
  logic        PCout = 0, Zhighout = 0, Zlowout = 0, HIout = 0, LOout = 0, MDRout = 0, InPortout = 0;
  logic [4:0]  opcode = '0;
  logic [31:0] BusMuxOut, MAR_q;

  datapath dut (
    .Clock(Clock), .clear(clear), .Mdatain(Mdatain), .Read(Read), .IncPC(IncPC),
    .Rin(Rin), .Rout(Rout), .PCin(PCin), .Zin(Zin), .MDRin(MDRin), .MARin(MARin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .PCout(PCout), .Zhighout(Zhighout),
    .Zlowout(Zlowout), .HIout(HIout), .LOout(LOout), .MDRout(MDRout),
    .InPortout(InPortout), .opcode(opcode), .InPort_data(InPort_data),
    .BusMuxOut(BusMuxOut), .MAR_q(MAR_q)
  );

  always #5 Clock = ~Clock;

  typedef struct { bit is_mar; logic [31:0] exp; string name; } chk_t;
  chk_t q[$];
  int total = 0;
  int bad = 0;

  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_hi, m_lo, m_y, m_mar, m_mdr;
  logic [63:0] m_z;

  function automatic logic [63:0] alu_ref(logic [31:0] a, logic [31:0] b, logic [4:0] op, logic inc);
    int sh;
    int ai, bi;
    longint ua, p, qq, rr;
    logic [31:0] r;
    sh = int'(b[4:0]);
    ai = a;
    bi = b;
    ua = longint'({32'd0, a});
    r  = '0;
    if (inc) return {32'd0, b + 32'd1};
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd12: r = 32'(ua + longint'({32'd0, b}));
      5'd4:         r = 32'(ua - longint'({32'd0, b}));
      5'd5, 5'd13:  r = a & b;
      5'd6, 5'd14:  r = a | b;
      5'd7:  begin r = a; repeat (sh) r = {r[0], r[31:1]}; end
      5'd8:  begin r = a; repeat (sh) r = {r[30:0], r[31]}; end
      5'd9:  r = 32'(ua / (64'sd1 << sh));
      5'd10: begin r = a; repeat (sh) r = {r[31], r[31:1]}; end
      5'd11: r = 32'(ua * (64'sd1 << sh));
      5'd15: begin p = longint'(ai) * longint'(bi); return 64'(p); end
      5'd16: begin
        if (b == 32'd0) return 64'd0;
        qq = longint'(ai) / longint'(bi);
        rr = longint'(ai) - qq * longint'(bi);
        return {32'(rr), 32'(qq)};
      end
      5'd17: r = 32'(-longint'({32'd0, b}));
      5'd18: r = ~b;
      default: r = '0;
    endcase
    return {32'd0, r};
  endfunction

  function automatic logic [31:0] model_bus();
    if (PCout)     return m_pc;
    if (MDRout)    return m_mdr;
    if (Zhighout)  return m_z[63:32];
    if (Zlowout)   return m_z[31:0];
    if (HIout)     return m_hi;
    if (LOout)     return m_lo;
    if (InPortout) return InPort_data;
    for (int n = 15; n >= 0; n--) if (Rout[n]) return m_r[n];
    return 32'd0;
  endfunction

  task automatic commit();
    logic [31:0] b;
    logic [63:0] c;
    b = model_bus();
    c = alu_ref(m_y, b, opcode, IncPC);
    if (clear) begin
      for (int n = 0; n < 16; n++) m_r[n] = '0;
      m_pc = '0; m_hi = '0; m_lo = '0; m_y = '0; m_mar = '0; m_mdr = '0; m_z = '0;
    end else begin
      for (int n = 0; n < 16; n++) if (Rin[n]) m_r[n] = b;
      if (PCin)  m_pc  = b;
      if (HIin)  m_hi  = b;
      if (LOin)  m_lo  = b;
      if (Yin)   m_y   = b;
      if (MARin) m_mar = b;
      if (MDRin) m_mdr = Read ? Mdatain : b;
      if (Zin)   m_z   = c;
    end
  endtask

  task automatic begin_cycle();
    @(posedge Clock);
    #1;
    clear = 0; Read = 0; IncPC = 0; Rin = '0; Rout = '0; opcode = '0; Mdatain = '0;
    PCin = 0; Zin = 0; MDRin = 0; MARin = 0; Yin = 0; HIin = 0; LOin = 0;
    PCout = 0; Zhighout = 0; Zlowout = 0; HIout = 0; LOout = 0; MDRout = 0; InPortout = 0;
  endtask

  task automatic chk_bus(string nm, logic [31:0] exp);
    q.push_back('{1'b0, exp, nm});
  endtask

  task automatic chk_mar(string nm, logic [31:0] exp);
    q.push_back('{1'b1, exp, nm});
  endtask

  task automatic load_r(int n, logic [31:0] v);
    begin_cycle(); Mdatain = v; Read = 1; MDRin = 1; commit();
    begin_cycle(); MDRout = 1; Rin[n] = 1'b1; commit();
  endtask

  task automatic read_r(string nm, int n, logic [31:0] exp);
    begin_cycle(); Rout[n] = 1'b1; chk_bus(nm, exp); commit();
  endtask

  task automatic alu_run(logic [31:0] a, logic [31:0] b, logic [4:0] op, logic inc);
    load_r(4, a);
    load_r(5, b);
    begin_cycle(); Rout[4] = 1'b1; Yin = 1; commit();
    begin_cycle(); Rout[5] = 1'b1; opcode = op; IncPC = inc; Zin = 1; commit();
  endtask

  task automatic read_z(string nm, logic [31:0] lo_exp, logic [31:0] hi_exp);
    begin_cycle(); Zlowout = 1;  chk_bus({nm, "_lo"}, lo_exp); commit();
    begin_cycle(); Zhighout = 1; chk_bus({nm, "_hi"}, hi_exp); commit();
  endtask

  // Monitor: everything queued this cycle is compared at the falling edge.
  always @(negedge Clock) begin
    chk_t c;
    logic [31:0] act;
    while (q.size() > 0) begin
      c = q.pop_front();
      act = c.is_mar ? MAR_q : BusMuxOut;
      total++;
      if (act !== c.exp) begin
        bad++;
        $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic [4:0]  op;
    logic        inc;

    begin_cycle(); clear = 1; commit();
    begin_cycle(); chk_bus("rst_bus", 32'd0); chk_mar("rst_mar", 32'd0); commit();

    load_r(2, 32'h12); load_r(3, 32'h14); load_r(1, 32'h18);
    begin_cycle(); Rout[2] = 1'b1; Yin = 1; commit();
    begin_cycle(); Rout[3] = 1'b1; opcode = OP_AND; Zin = 1; commit();
    begin_cycle(); Zlowout = 1; Rin[1] = 1'b1; commit();
    read_r("and_r1", 1, 32'h10);
    begin_cycle(); Zhighout = 1; chk_bus("and_zhi", 32'd0); commit();

    begin_cycle(); Mdatain = 32'd5; Read = 1; MDRin = 1; commit();
    begin_cycle(); MDRout = 1; PCin = 1; commit();
    begin_cycle(); PCout = 1; MARin = 1; IncPC = 1; Zin = 1; commit();
    begin_cycle(); Zlowout = 1; PCin = 1; commit();
    begin_cycle(); PCout = 1; chk_mar("pc_mar", 32'd5); chk_bus("pc_inc", 32'd6); commit();

    alu_run(-32'sd3, 32'd7, OP_MUL, 0);  read_z("mul", 32'hFFFFFFEB, 32'hFFFFFFFF);
    alu_run(-32'sd7, 32'd2, OP_DIV, 0);  read_z("div", 32'hFFFFFFFD, 32'hFFFFFFFF);
    alu_run(32'd123, 32'd0, OP_DIV, 0);  read_z("div0", 32'd0, 32'd0);
    alu_run(32'h80000001, 32'd1, OP_ROR, 0);  read_z("ror", 32'hC0000000, 32'd0);
    alu_run(32'h80000001, 32'd1, OP_SHRA, 0); read_z("shra", 32'hC0000000, 32'd0);
    alu_run(32'h80000001, 32'd1, OP_SHR, 0);  read_z("shr", 32'h40000000, 32'd0);
    alu_run(32'h80000001, 32'd1, OP_SHL, 0);  read_z("shl", 32'h00000002, 32'd0);

    load_r(1, 32'hAAAA5555);
    begin_cycle(); PCout = 1; Rout[1] = 1'b1; chk_bus("prio_pc", 32'd6); commit();
    begin_cycle(); MDRout = 1; Zlowout = 1; Rout[1] = 1'b1; chk_bus("prio_mdr", model_bus()); commit();
    load_r(6, 32'h13579BDF);
    begin_cycle(); Rout[6] = 1'b1; MDRin = 1; Read = 0; Mdatain = 32'hDEADBEEF; commit();
    begin_cycle(); MDRout = 1; chk_bus("mdr_bus", 32'h13579BDF); commit();
    begin_cycle(); Rout[6] = 1'b1; Rin[6] = 1'b1; Rin[7] = 1'b1; commit();
    read_r("self_r6", 6, 32'h13579BDF);
    read_r("multi_r7", 7, 32'h13579BDF);
    begin_cycle(); InPort_data = 32'h0BADF00D; InPortout = 1; HIin = 1; commit();
    begin_cycle(); Rout[1] = 1'b1; LOin = 1; commit();
    begin_cycle(); HIout = 1; LOout = 1; chk_bus("hi", 32'h0BADF00D); commit();
    begin_cycle(); LOout = 1; chk_bus("lo", 32'hAAAA5555); commit();

    for (int i = 0; i < 60; i++) begin
      a   = $urandom();
      b   = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom();
      op  = 5'($urandom_range(0, 31));
      inc = ($urandom_range(0, 7) == 0);
      if (op == OP_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
      alu_run(a, b, op, inc);
      read_z($sformatf("rnd%0d_op%0d", i, op), m_z[31:0], m_z[63:32]);
    end

    for (int n = 0; n < 16; n++) load_r(n, 32'h100 + 32'(n));
    begin_cycle(); Rout[3] = 1'b1; PCin = 1; HIin = 1; LOin = 1; Yin = 1; MARin = 1; commit();
    begin_cycle(); Rout[5] = 1'b1; opcode = OP_ADD; Zin = 1; commit();
    begin_cycle(); Mdatain = 32'h55; Read = 1; MDRin = 1; commit();
    begin_cycle();
    clear = 1; Rin = '1; PCin = 1; HIin = 1; LOin = 1; Yin = 1; MARin = 1; MDRin = 1; Zin = 1;
    Rout[3] = 1'b1; opcode = OP_ADD;
    commit();
    begin_cycle(); chk_bus("clr_bus", 32'd0); chk_mar("clr_mar", 32'd0); commit();
    for (int n = 0; n < 16; n++) read_r($sformatf("clr_r%0d", n), n, 32'd0);
    begin_cycle(); PCout = 1;  chk_bus("clr_pc", 32'd0); commit();
    begin_cycle(); HIout = 1;  chk_bus("clr_hi", 32'd0); commit();
    begin_cycle(); LOout = 1;  chk_bus("clr_lo", 32'd0); commit();
    begin_cycle(); MDRout = 1; chk_bus("clr_mdr", 32'd0); commit();
    read_z("clr_z", 32'd0, 32'd0);
    begin_cycle(); Rout[0] = 1'b1; opcode = OP_ADD; Zin = 1; commit();
    read_z("clr_y", 32'd0, 32'd0);

    begin_cycle();
    @(negedge Clock);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL pending: %0d expectations never compared", q.size());
    end
    if (total < 12) begin
      bad++;
      $display("FAIL coverage: only %0d checks performed", total);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad == 0) $display("PASS");
    else $display("FAIL: %0d mismatches", bad);
    $finish;
  end

endmodule
